// File: rtl/led_seq_counter.sv
// led_seq_counter: prescaled LED bank counter with up/down/bounce/hold modes.
// A single clk domain throughout; the prescaler produces a one-cycle step tick
// (clock enable) rather than a derived clock.
module led_seq_counter #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DIV_BITS = 24,
  parameter int unsigned SEL_BITS = 2,
  parameter int unsigned TAP_LO   = 20,
  parameter bit          WRAP     = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SEL_BITS-1:0] sel,
  input  logic [1:0]          mode,
  input  logic                en,
  input  logic                load,
  input  logic [WIDTH-1:0]    load_val,
  output logic [WIDTH-1:0]    led,
  output logic                dir,
  output logic                tick,
  output logic                tc
);

  localparam int unsigned IDX_W = (DIV_BITS > 1) ? $clog2(DIV_BITS) : 1;
  localparam logic [WIDTH-1:0] MAX = '1;

  typedef enum logic [1:0] {
    MODE_UP     = 2'b00,
    MODE_DOWN   = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  logic [DIV_BITS-1:0] r_presc;
  logic [SEL_BITS-1:0] r_sel_q;
  logic                r_tap_q;
  logic                r_tick;
  logic [WIDTH-1:0]    r_led;
  logic                r_dir;
  logic                r_tc;

  logic [IDX_W-1:0]    w_tap_idx;
  logic [IDX_W-1:0]    w_new_idx;
  logic                w_tap;
  logic                w_new_tap;
  logic                w_sel_chg;
  logic                w_step;
  logic [WIDTH-1:0]    w_led_nxt;
  logic                w_dir_nxt;
  logic                w_tc_nxt;

  // Tap selection for the registered rate and for an incoming rate change.
  assign w_tap_idx = IDX_W'(TAP_LO) + IDX_W'(r_sel_q);
  assign w_new_idx = IDX_W'(TAP_LO) + IDX_W'(sel);
  assign w_tap     = r_presc[w_tap_idx];
  assign w_new_tap = r_presc[w_new_idx];
  assign w_sel_chg = (sel != r_sel_q);

  // Free-running prescaler, rate register and tap rising-edge detector.
  // On a rate change the edge detector is reloaded from the new tap and the
  // tick is suppressed so the switch never produces a spurious step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
      r_sel_q <= '0;
      r_tap_q <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_presc <= r_presc + DIV_BITS'(1);
      r_sel_q <= sel;
      if (w_sel_chg) begin
        r_tap_q <= w_new_tap;
        r_tick  <= 1'b0;
      end else begin
        r_tap_q <= w_tap;
        r_tick  <= w_tap & ~r_tap_q;
      end
    end
  end

  // Next counter value, direction and terminal-count strobe.
  always_comb begin
    w_led_nxt = r_led;
    w_dir_nxt = r_dir;
    w_tc_nxt  = 1'b0;
    w_step    = r_tick & en & (mode != MODE_HOLD);
    if (load) begin
      w_led_nxt = load_val;
    end else if (w_step) begin
      unique case (mode_e'(mode))
        MODE_UP: begin
          w_dir_nxt = 1'b1;
          if (r_led == MAX) begin
            w_tc_nxt  = 1'b1;
            w_led_nxt = WRAP ? '0 : MAX;
          end else begin
            w_led_nxt = r_led + WIDTH'(1);
          end
        end
        MODE_DOWN: begin
          w_dir_nxt = 1'b0;
          if (r_led == '0) begin
            w_tc_nxt  = 1'b1;
            w_led_nxt = WRAP ? MAX : '0;
          end else begin
            w_led_nxt = r_led - WIDTH'(1);
          end
        end
        MODE_BOUNCE: begin
          if (r_dir) begin
            if (r_led == MAX) begin
              w_led_nxt = MAX - WIDTH'(1);
              w_dir_nxt = 1'b0;
              w_tc_nxt  = 1'b1;
            end else begin
              w_led_nxt = r_led + WIDTH'(1);
            end
          end else begin
            if (r_led == '0) begin
              w_led_nxt = WIDTH'(1);
              w_dir_nxt = 1'b1;
              w_tc_nxt  = 1'b1;
            end else begin
              w_led_nxt = r_led - WIDTH'(1);
            end
          end
        end
        default: begin
          w_led_nxt = r_led;
        end
      endcase
    end
  end

  // Counter state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_led <= '0;
      r_dir <= 1'b1;
      r_tc  <= 1'b0;
    end else begin
      r_led <= w_led_nxt;
      r_dir <= w_dir_nxt;
      r_tc  <= w_tc_nxt;
    end
  end

  assign led  = r_led;
  assign dir  = r_dir;
  assign tick = r_tick;
  assign tc   = r_tc;

endmodule

// File: tb/tb_led_seq_counter.sv
// Testbench for led_seq_counter: a wrapping and a saturating instance share
// stimulus and are compared every cycle against an arithmetic reference model.
module tb_led_seq_counter;

  localparam int unsigned W  = 4;
  localparam int unsigned DB = 8;
  localparam int unsigned SB = 2;
  localparam int unsigned TL = 0;
  localparam int MAXV = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic [SB-1:0] sel;
  logic [1:0]    mode;
  logic          en;
  logic          load;
  logic [W-1:0]  load_val;
  logic [W-1:0]  led_w, led_s;
  logic          dir_w, dir_s, tick_w, tick_s, tc_w, tc_s;

  int checks = 0;
  int errors = 0;

  // Reference model state: prescaler count, tick generator, and per-instance counter.
  int m_presc, m_selq, m_tapq, m_tick;
  int m_led [2];
  int m_dir [2];
  int m_tc  [2];

  always #5 clk = ~clk;

  led_seq_counter #(.WIDTH(W), .DIV_BITS(DB), .SEL_BITS(SB), .TAP_LO(TL), .WRAP(1'b1)) u_wrap (
    .clk(clk), .reset(reset), .sel(sel), .mode(mode), .en(en), .load(load),
    .load_val(load_val), .led(led_w), .dir(dir_w), .tick(tick_w), .tc(tc_w));

  led_seq_counter #(.WIDTH(W), .DIV_BITS(DB), .SEL_BITS(SB), .TAP_LO(TL), .WRAP(1'b0)) u_sat (
    .clk(clk), .reset(reset), .sel(sel), .mode(mode), .en(en), .load(load),
    .load_val(load_val), .led(led_s), .dir(dir_s), .tick(tick_s), .tc(tc_s));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_presc = 0; m_selq = 0; m_tapq = 0; m_tick = 0;
    for (int k = 0; k < 2; k++) begin
      m_led[k] = 0; m_dir[k] = 1; m_tc[k] = 0;
    end
  endtask

  task automatic check_all();
    chk("led_wrap",  led_w,  m_led[0]);
    chk("dir_wrap",  dir_w,  m_dir[0]);
    chk("tc_wrap",   tc_w,   m_tc[0]);
    chk("tick_wrap", tick_w, m_tick);
    chk("led_sat",   led_s,  m_led[1]);
    chk("dir_sat",   dir_s,  m_dir[1]);
    chk("tc_sat",    tc_s,   m_tc[1]);
    chk("tick_sat",  tick_s, m_tick);
  endtask

  // Advance one clock: model computes next state from present inputs, then outputs are checked.
  task automatic clk_cycle();
    int presc_n, tick_n, tapq_n, selq_n, tap;
    int led_n [2];
    int dir_n [2];
    int tc_n  [2];
    bit step;
    presc_n = (m_presc + 1) % (1 << DB);
    tap = (m_presc >> (TL + m_selq)) & 1;
    if (int'(sel) != m_selq) begin
      tick_n = 0;
      tapq_n = (m_presc >> (TL + int'(sel))) & 1;
      selq_n = int'(sel);
    end else begin
      tick_n = (tap == 1 && m_tapq == 0) ? 1 : 0;
      tapq_n = tap;
      selq_n = m_selq;
    end
    step = (m_tick == 1) && en && (mode != 2'd3);
    for (int k = 0; k < 2; k++) begin
      int v, d, t;
      bit wrap;
      wrap = (k == 0);
      v = m_led[k]; d = m_dir[k]; t = 0;
      if (load) begin
        v = int'(load_val);
      end else if (step) begin
        case (mode)
          2'd0: begin
            d = 1; v = v + 1;
            if (v > MAXV) begin t = 1; v = wrap ? 0 : MAXV; end
          end
          2'd1: begin
            d = 0; v = v - 1;
            if (v < 0) begin t = 1; v = wrap ? MAXV : 0; end
          end
          default: begin
            v = v + ((d == 1) ? 1 : -1);
            if (v > MAXV) begin v = MAXV - 1; d = 0; t = 1; end
            if (v < 0)    begin v = 1;        d = 1; t = 1; end
          end
        endcase
      end
      led_n[k] = v; dir_n[k] = d; tc_n[k] = t;
    end
    @(posedge clk);
    #1;
    m_presc = presc_n; m_tick = tick_n; m_tapq = tapq_n; m_selq = selq_n;
    for (int k = 0; k < 2; k++) begin
      m_led[k] = led_n[k]; m_dir[k] = dir_n[k]; m_tc[k] = tc_n[k];
    end
    check_all();
  endtask

  // Run until the model's tick is high, then take the edge that performs the step.
  task automatic run_step();
    for (int i = 0; i < 40; i++) begin
      if (m_tick == 1) begin
        clk_cycle();
        return;
      end
      clk_cycle();
    end
    checks++;
    errors++;
    $error("FAIL step_timeout observed=no_tick expected=tick_within_40");
  endtask

  // Cycles between consecutive DUT tick pulses, bounded.
  task automatic measure_period(output int p);
    int n;
    n = 0;
    while (tick_w !== 1'b1 && n < 64) begin clk_cycle(); n++; end
    clk_cycle();
    p = 1;
    while (tick_w !== 1'b1 && p < 64) begin clk_cycle(); p++; end
  endtask

  initial begin
    int p, saved, nt;
    reset = 1'b1; sel = '0; mode = 2'd0; en = 1'b1; load = 1'b0; load_val = '0;
    model_reset();
    #12;
    chk("rst_led", led_w, 4'h0);
    chk("rst_dir", dir_w, 1'b1);
    chk("rst_tick", tick_w, 1'b0);
    chk("rst_tc", tc_w, 1'b0);
    reset = 1'b0;

    // Up with wrap / saturate.
    load = 1'b1; load_val = 4'hE; clk_cycle(); load = 1'b0;
    chk("t1_load", led_w, 4'hE);
    run_step(); chk("t1_F", led_w, 4'hF); chk("t1_tc0", tc_w, 1'b0);
    run_step(); chk("t1_wrap0", led_w, 4'h0); chk("t1_tcw", tc_w, 1'b1);
    chk("t1_satF", led_s, 4'hF); chk("t1_tcs", tc_s, 1'b1);
    run_step(); chk("t1_1", led_w, 4'h1); chk("t1_tc_off", tc_w, 1'b0);
    chk("t1_satF2", led_s, 4'hF); chk("t1_tcs2", tc_s, 1'b1); chk("t1_dir", dir_w, 1'b1);

    // Down with wrap.
    mode = 2'd1; load = 1'b1; load_val = 4'h1; clk_cycle(); load = 1'b0;
    run_step(); chk("t2_0", led_w, 4'h0); chk("t2_dir", dir_w, 1'b0);
    run_step(); chk("t2_F", led_w, 4'hF); chk("t2_tc", tc_w, 1'b1);
    chk("t2_sat0", led_s, 4'h0); chk("t2_tcs", tc_s, 1'b1);

    // Bounce at the top and at the bottom.
    mode = 2'd0; load = 1'b1; load_val = 4'hC; clk_cycle(); load = 1'b0;
    run_step(); chk("t3_D", led_w, 4'hD);
    mode = 2'd2;
    run_step(); chk("t3_E", led_w, 4'hE);
    run_step(); chk("t3_F", led_w, 4'hF); chk("t3_dirF", dir_w, 1'b1);
    run_step(); chk("t3_E2", led_w, 4'hE); chk("t3_dirfall", dir_w, 1'b0); chk("t3_tc", tc_w, 1'b1);
    run_step(); chk("t3_D2", led_s, 4'hD); chk("t3_tc_off", tc_s, 1'b0);
    load = 1'b1; load_val = 4'h1; clk_cycle(); load = 1'b0;
    run_step(); chk("t3_0", led_w, 4'h0); chk("t3_tc0", tc_w, 1'b0);
    run_step(); chk("t3_1", led_w, 4'h1); chk("t3_dirrise", dir_w, 1'b1); chk("t3_tcb", tc_w, 1'b1);

    // Rate select and enable.
    mode = 2'd3; sel = 2'd2;
    for (int i = 0; i < 10; i++) clk_cycle();
    measure_period(p); chk("t4_period8", p, 8);
    clk_cycle(); clk_cycle(); clk_cycle();
    sel = 2'd0; clk_cycle(); chk("t4_nospur", tick_w, 1'b0);
    measure_period(p); chk("t4_period2", p, 2);
    mode = 2'd0; en = 1'b0; saved = m_led[0]; nt = 0;
    for (int i = 0; i < 10; i++) begin clk_cycle(); if (m_tick == 1) nt++; end
    chk("t4_frozen", led_w, saved); chk("t4_tc_en0", tc_w, 1'b0); chk("t4_ticks_en0", nt > 0, 1);
    en = 1'b1;

    // Load colliding with a step, then hold.
    load = 1'b1; load_val = 4'hF; clk_cycle(); load = 1'b0;
    for (int i = 0; i < 8 && m_tick == 0; i++) clk_cycle();
    load = 1'b1; load_val = 4'h5; clk_cycle(); load = 1'b0;
    chk("t5_led5", led_w, 4'h5); chk("t5_tc", tc_w, 1'b0);
    mode = 2'd3; nt = 0;
    for (int i = 0; i < 12; i++) begin clk_cycle(); if (m_tick == 1) nt++; end
    chk("t5_hold", led_w, 4'h5); chk("t5_ticks", nt > 0, 1);

    // Asynchronous reset between ticks.
    mode = 2'd1; load = 1'b1; load_val = 4'hA; clk_cycle(); load = 1'b0;
    run_step(); chk("t6_9", led_w, 4'h9); chk("t6_dir0", dir_w, 1'b0);
    #3 reset = 1'b1;
    #1;
    chk("t6_led", led_w, 4'h0); chk("t6_dir", dir_w, 1'b1);
    chk("t6_tick", tick_w, 1'b0); chk("t6_tc", tc_w, 1'b0);
    model_reset();
    #1 reset = 1'b0;
    clk_cycle(); chk("t6_tick1", tick_w, 1'b0);
    clk_cycle(); chk("t6_tick2", tick_w, 1'b1);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom % 16 == 0) sel = SB'($urandom);
      if ($urandom % 8 == 0)  mode = 2'($urandom);
      en = ($urandom % 8) != 0;
      load = ($urandom % 12) == 0;
      load_val = W'($urandom);
      clk_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
